// File: rtl/uart_dbg_fmt.sv
// uart_dbg_fmt: debug UART transmitter with a word queue.
// Each queued word is sent as 8N1 characters, either as raw little-endian
// bytes or as uppercase ASCII hex followed by CR LF. Writes that arrive while
// the queue is full are counted in a saturating dropped counter.
module uart_dbg_fmt #(
    parameter int unsigned SYS_CLK_FREQ   = 12000000,
    parameter int unsigned BAUD_RATE      = 115200,
    parameter int unsigned DATA_WIDTH     = 8,
    parameter int unsigned MSG_QUEUE_SIZE = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr,
    input  logic [DATA_WIDTH-1:0] msg,
    input  logic                  hex_mode,
    output logic                  tx,
    output logic                  full,
    output logic                  empty,
    output logic                  busy,
    output logic [7:0]            dropped
);

    localparam int unsigned CLKS_PER_BIT = ((SYS_CLK_FREQ / BAUD_RATE) > 0) ?
                                           (SYS_CLK_FREQ / BAUD_RATE) : 1;
    localparam int unsigned CNT_W     = $clog2(CLKS_PER_BIT + 1);
    localparam int unsigned N_HEX_DIG = DATA_WIDTH / 4;
    localparam int unsigned N_RAW     = DATA_WIDTH / 8;
    localparam int unsigned N_HEX     = N_HEX_DIG + 2;
    localparam int unsigned IDX_W     = $clog2(N_HEX + 1);
    localparam int unsigned ADDR_W    = $clog2(MSG_QUEUE_SIZE);
    localparam int unsigned QCNT_W    = $clog2(MSG_QUEUE_SIZE + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t state, state_nxt;

    // ------------------------------------------------------------------
    // Word queue
    // ------------------------------------------------------------------
    logic [DATA_WIDTH:0]   mem [MSG_QUEUE_SIZE];
    logic [ADDR_W-1:0]     wr_ptr, rd_ptr;
    logic [QCNT_W-1:0]     q_cnt, q_cnt_nxt;
    logic                  do_push, do_pop;
    logic [DATA_WIDTH:0]   head;

    // full is the registered flag, so a write on a full queue is dropped even
    // when a pop frees a slot on the same edge.
    assign do_push = wr & ~full;
    assign do_pop  = (state == IDLE) & ~empty;
    assign head    = mem[rd_ptr];

    // Next occupancy from the push/pop pair of this edge.
    always_comb begin
        q_cnt_nxt = q_cnt;
        case ({do_push, do_pop})
            2'b10:   q_cnt_nxt = q_cnt + QCNT_W'(1);
            2'b01:   q_cnt_nxt = q_cnt - QCNT_W'(1);
            default: q_cnt_nxt = q_cnt;
        endcase
    end

    // Queue storage; entries carry the format bit captured with the word.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= {hex_mode, msg};
        end
    end

    // Queue pointers, occupancy and registered full/empty flags.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            q_cnt  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + ADDR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + ADDR_W'(1);
            q_cnt <= q_cnt_nxt;
            full  <= (q_cnt_nxt == QCNT_W'(MSG_QUEUE_SIZE));
            empty <= (q_cnt_nxt == '0);
        end
    end

    // Saturating count of rejected writes.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            dropped <= '0;
        end else if (wr && full && (dropped != 8'hFF)) begin
            dropped <= dropped + 8'd1;
        end
    end

    // ------------------------------------------------------------------
    // Serialiser
    // ------------------------------------------------------------------
    logic [DATA_WIDTH-1:0] word_sr;
    logic                  mode_r;
    logic [IDX_W-1:0]      char_idx;
    logic [2:0]            bit_idx;
    logic [CNT_W-1:0]      clk_cnt;
    logic                  bit_end;
    logic                  last_char;
    logic [3:0]            nib;
    logic [7:0]            cur_char;

    assign bit_end   = (clk_cnt == CNT_W'(CLKS_PER_BIT - 1));
    assign last_char = mode_r ? (char_idx == IDX_W'(N_HEX - 1))
                              : (char_idx == IDX_W'(N_RAW - 1));
    assign nib       = word_sr[DATA_WIDTH-1 -: 4];

    // Character being sent: raw takes the low byte, hex takes the top nibble
    // (the word shifts between characters), then CR and LF by index.
    always_comb begin
        cur_char = 8'h0A;
        if (!mode_r) begin
            cur_char = word_sr[7:0];
        end else if (char_idx < IDX_W'(N_HEX_DIG)) begin
            cur_char = (nib < 4'd10) ? {4'h3, nib} : (8'h37 + {4'h0, nib});
        end else if (char_idx == IDX_W'(N_HEX_DIG)) begin
            cur_char = 8'h0D;
        end else begin
            cur_char = 8'h0A;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic and line outputs; tx depends only on state so reset
    // forces the line idle without a clock.
    always_comb begin
        state_nxt = state;
        tx        = 1'b1;
        busy      = 1'b1;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (!empty) state_nxt = START;
            end
            START: begin
                tx = 1'b0;
                if (bit_end) state_nxt = DATA;
            end
            DATA: begin
                tx = cur_char[bit_idx];
                if (bit_end && (bit_idx == 3'd7)) state_nxt = STOP;
            end
            STOP: begin
                tx = 1'b1;
                if (bit_end) state_nxt = last_char ? IDLE : START;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Bit timing, bit/character indices and the word shift register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            word_sr  <= '0;
            mode_r   <= 1'b0;
            char_idx <= '0;
            bit_idx  <= '0;
            clk_cnt  <= '0;
        end else if (do_pop) begin
            word_sr  <= head[DATA_WIDTH-1:0];
            mode_r   <= head[DATA_WIDTH];
            char_idx <= '0;
            bit_idx  <= '0;
            clk_cnt  <= '0;
        end else if (state != IDLE) begin
            clk_cnt <= bit_end ? '0 : clk_cnt + CNT_W'(1);
            if ((state == DATA) && bit_end) begin
                bit_idx <= bit_idx + 3'd1;
            end
            if ((state == STOP) && bit_end) begin
                char_idx <= char_idx + IDX_W'(1);
                word_sr  <= mode_r ? (word_sr << 4) : (word_sr >> 8);
            end
        end
    end

endmodule

// File: tb/tb_uart_dbg_fmt.sv
// tb_uart_dbg_fmt: self-checking bench for uart_dbg_fmt with a serial
// receiver model, a byte scoreboard and a busy/idle run-length monitor.
module tb_uart_dbg_fmt;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        wr = 1'b0;
    logic        hex_mode = 1'b0;
    logic [15:0] msg = '0;
    logic        tx, full, empty, busy;
    logic [7:0]  dropped;

    int tests = 0;
    int fails = 0;
    int abort_req = 0;

    logic [7:0] exp_q[$];
    int         busy_q[$];
    int         gap_q[$];

    uart_dbg_fmt #(
        .SYS_CLK_FREQ  (4),
        .BAUD_RATE     (1),
        .DATA_WIDTH    (16),
        .MSG_QUEUE_SIZE(4)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .wr      (wr),
        .msg     (msg),
        .hex_mode(hex_mode),
        .tx      (tx),
        .full    (full),
        .empty   (empty),
        .busy    (busy),
        .dropped (dropped)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] hex_char(input logic [3:0] n);
        if (n <= 4'd9) return 8'h30 + 8'(n);
        return 8'h41 + 8'(n) - 8'd10;
    endfunction

    task automatic push_word(input logic [15:0] w, input logic h);
        logic [15:0] t;
        t = w;
        if (!h) begin
            exp_q.push_back(t[7:0]);
            exp_q.push_back(t[15:8]);
        end else begin
            for (int i = 3; i >= 0; i--) exp_q.push_back(hex_char(t[4*i +: 4]));
            exp_q.push_back(8'h0D);
            exp_q.push_back(8'h0A);
        end
    endtask

    task automatic wait_drain(input string tag);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || busy) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check(tag, 32'(exp_q.size()), 32'd0);
        repeat (30) @(negedge clk);
    endtask

    // Serial receiver: samples mid-bit on falling clock edges.
    initial begin : rx_proc
        logic [7:0] b;
        int         abort_seen;
        abort_seen = 0;
        b = '0;
        forever begin
            @(negedge clk);
            if (reset && tx == 1'b0) begin
                @(negedge clk);
                check("rx_start", 32'(tx), 32'd0);
                for (int i = 0; i < 8; i++) begin
                    repeat (4) @(negedge clk);
                    b[i] = tx;
                end
                repeat (4) @(negedge clk);
                if (abort_seen != abort_req) begin
                    abort_seen = abort_req;
                end else begin
                    check("rx_stop", 32'(tx), 32'd1);
                    if (exp_q.size() == 0) check("rx_extra", 32'(b), 32'h100);
                    else check("rx_byte", 32'(b), 32'(exp_q.pop_front()));
                end
            end
        end
    end

    // Busy run lengths and short idle gaps between words.
    int mon_blen = 0;
    int mon_glen = 0;
    logic mon_prev = 1'b0;
    always @(negedge clk) begin
        if (busy) begin
            if (!mon_prev && mon_glen > 0 && mon_glen <= 20) gap_q.push_back(mon_glen);
            mon_blen = mon_blen + 1;
            mon_glen = 0;
        end else begin
            if (mon_prev) busy_q.push_back(mon_blen);
            mon_blen = 0;
            mon_glen = mon_glen + 1;
        end
        mon_prev = busy;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int bb, gb;
        logic [15:0] t6_w [3];
        logic        t6_h [3];

        // Reset values
        repeat (3) @(negedge clk);
        check("rst_tx", 32'(tx), 32'd1);
        check("rst_full", 32'(full), 32'd0);
        check("rst_empty", 32'(empty), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_dropped", 32'(dropped), 32'd0);
        reset = 1'b1;
        repeat (3) @(negedge clk);

        // T1: single raw word
        bb = busy_q.size();
        wr = 1'b1; msg = 16'hA55A; hex_mode = 1'b0;
        push_word(16'hA55A, 1'b0);
        @(negedge clk);
        wr = 1'b0;
        check("t1_empty_after_wr", 32'(empty), 32'd0);
        check("t1_tx_idle", 32'(tx), 32'd1);
        check("t1_busy_idle", 32'(busy), 32'd0);
        @(negedge clk);
        check("t1_tx_start", 32'(tx), 32'd0);
        check("t1_busy", 32'(busy), 32'd1);
        check("t1_empty_after_pop", 32'(empty), 32'd1);
        wait_drain("t1_drain");
        check("t1_busy_runs", 32'(busy_q.size() - bb), 32'd1);
        check("t1_busy_len", 32'(busy_q[bb]), 32'd80);

        // T2: hex word, hex_mode toggled during transmission
        bb = busy_q.size();
        wr = 1'b1; msg = 16'h1F0C; hex_mode = 1'b1;
        push_word(16'h1F0C, 1'b1);
        @(negedge clk);
        wr = 1'b0;
        for (int i = 0; i < 60; i++) begin
            hex_mode = ~hex_mode;
            @(negedge clk);
        end
        hex_mode = 1'b0;
        wait_drain("t2_drain");
        check("t2_busy_len", 32'(busy_q[bb]), 32'd240);

        // T3: six raw writes on consecutive edges
        bb = busy_q.size();
        gb = gap_q.size();
        for (int i = 1; i <= 6; i++) begin
            if (i == 5) check("t3_not_full", 32'(full), 32'd0);
            if (i == 6) check("t3_full", 32'(full), 32'd1);
            wr = 1'b1; msg = 16'(i); hex_mode = 1'b0;
            if (i <= 5) push_word(16'(i), 1'b0);
            @(negedge clk);
        end
        wr = 1'b0;
        check("t3_dropped", 32'(dropped), 32'd1);
        wait_drain("t3_drain");
        check("t3_busy_runs", 32'(busy_q.size() - bb), 32'd5);
        check("t3_busy_len", 32'(busy_q[bb+4]), 32'd80);
        check("t3_gaps", 32'(gap_q.size() - gb), 32'd4);
        for (int i = 0; i < 4; i++) check("t3_gap_len", 32'(gap_q[gb+i]), 32'd1);

        // T4: wr held high for 300 cycles
        for (int k = 1; k <= 300; k++) begin
            wr = 1'b1; msg = 16'(k); hex_mode = 1'b0;
            if (k <= 5 || k == 84 || k == 165 || k == 246) push_word(16'(k), 1'b0);
            @(negedge clk);
        end
        wr = 1'b0;
        check("t4_dropped_sat", 32'(dropped), 32'd255);
        wait_drain("t4_drain");
        check("t4_dropped_hold", 32'(dropped), 32'd255);

        // T5: reset during the first data bit
        wr = 1'b1; msg = 16'h1234; hex_mode = 1'b0;
        push_word(16'h1234, 1'b0);
        @(negedge clk);
        wr = 1'b0;
        repeat (8) @(negedge clk);
        check("t5_in_frame", 32'(busy), 32'd1);
        reset = 1'b0;
        abort_req++;
        exp_q.delete();
        #1;
        check("t5_rst_tx", 32'(tx), 32'd1);
        check("t5_rst_busy", 32'(busy), 32'd0);
        check("t5_rst_empty", 32'(empty), 32'd1);
        check("t5_rst_dropped", 32'(dropped), 32'd0);
        repeat (60) @(negedge clk);
        reset = 1'b1;
        repeat (5) @(negedge clk);
        check("t5_post_tx", 32'(tx), 32'd1);
        wr = 1'b1; msg = 16'h0041; hex_mode = 1'b0;
        push_word(16'h0041, 1'b0);
        @(negedge clk);
        wr = 1'b0;
        wait_drain("t5_drain");

        // T6: alternating formats back-to-back
        bb = busy_q.size();
        gb = gap_q.size();
        t6_w[0] = 16'h1234; t6_h[0] = 1'b0;
        t6_w[1] = 16'h00FF; t6_h[1] = 1'b1;
        t6_w[2] = 16'hBEEF; t6_h[2] = 1'b0;
        for (int i = 0; i < 3; i++) begin
            wr = 1'b1; msg = t6_w[i]; hex_mode = t6_h[i];
            push_word(t6_w[i], t6_h[i]);
            @(negedge clk);
        end
        wr = 1'b0; hex_mode = 1'b0;
        wait_drain("t6_drain");
        check("t6_len0", 32'(busy_q[bb]), 32'd80);
        check("t6_len1", 32'(busy_q[bb+1]), 32'd240);
        check("t6_len2", 32'(busy_q[bb+2]), 32'd80);
        check("t6_gaps", 32'(gap_q.size() - gb), 32'd2);
        check("t6_gap0", 32'(gap_q[gb]), 32'd1);
        check("t6_gap1", 32'(gap_q[gb+1]), 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/uart_dbg_fmt.md
# uart_dbg_fmt

Parametrised debug UART transmitter. It queues DATA_WIDTH-bit words and serialises each one as 8N1 UART characters, in one of two per-word modes: raw little-endian bytes, or uppercase ASCII hex terminated by CR LF. It sits between design logic and the board TX pin, replacing the byte-only debug transmitter. It adds word width, hex formatting, and overflow accounting.

## Interface
- SYS_CLK_FREQ, 12000000, system clock frequency in Hz
- BAUD_RATE, 115200, serial bit rate; CLKS_PER_BIT = max(1, SYS_CLK_FREQ / BAUD_RATE), integer division
- DATA_WIDTH, 8, word width in bits; must be a multiple of 8 and at least 8
- MSG_QUEUE_SIZE, 8, queue depth in words; must be a power of 2 and at least 2
- clk  in  1  system clock; all logic on rising edge
- reset  in  1  asynchronous, active-low reset
- wr  in  1  enqueue request; sampled at rising clk edge
- msg  in  DATA_WIDTH  word to enqueue when wr=1
- hex_mode  in  1  format for this word, stored alongside it: 1 = ASCII hex, 0 = raw
- tx  out  1  UART serial output; idle high
- full  out  1  queue holds MSG_QUEUE_SIZE words
- empty  out  1  queue holds 0 words
- busy  out  1  serialiser is transmitting a word
- dropped  out  8  saturating count of writes rejected because the queue was full

## Operation
- Queue entries are {hex_mode, msg}, captured at the write edge. Later changes to hex_mode never affect queued or in-flight words.
- Write with full=1 (value registered before the edge) is dropped, even if a pop happens on the same edge. dropped increments and saturates at 255.
- Pop and non-full write on the same edge: both take effect; the count is unchanged.
- Serialiser FSM states: IDLE, START, DATA, STOP.
  - IDLE → START when the queue is non-empty. The head word is popped into the shift register, and the character index and mode are loaded.
  - START: tx=0 for CLKS_PER_BIT cycles.
  - DATA: 8 bits, LSB first, each for CLKS_PER_BIT cycles.
  - STOP: tx=1 for CLKS_PER_BIT cycles. If characters remain in the word, go to START for the next character with no gap. Otherwise go to IDLE.
- Raw mode: DATA_WIDTH/8 characters, least-significant byte first.
- Hex mode: DATA_WIDTH/4 characters, most-significant nibble first, then 0x0D and 0x0A.
  - Nibble 0–9 maps to 0x30–0x39.
  - Nibble A–F maps to 0x41–0x46.
- busy=1 in every state except IDLE.
- tx=1 in IDLE.
- Bit counter width is $clog2(CLKS_PER_BIT+1). The bit-timing counter restarts at each bit boundary, so there is no cumulative drift.

## Timing
- Reset values (low level, applied immediately): tx=1, full=0, empty=1, busy=0, dropped=0. The queue is cleared and the FSM goes to IDLE.
- Reset low mid-frame aborts the frame: tx goes to 1 without waiting for a clock. No partial character resumes after release.
- full, empty and dropped are registered and update on the edge after the write or pop.
- Latency with IDLE and empty queue:
  - write at edge N: empty=0 after edge N
  - pop at edge N+1: tx falls (start bit) after edge N+1
  - empty=1 again after edge N+1 if no further writes
- Each character lasts 10·CLKS_PER_BIT cycles. A raw word lasts DATA_WIDTH/8 · 10 · CLKS_PER_BIT cycles. A hex word lasts (DATA_WIDTH/4 + 2) · 10 · CLKS_PER_BIT cycles.
- Between consecutive words, the FSM spends exactly 1 cycle in IDLE with tx=1 and busy=0.

## Test plan
Bench parameters: SYS_CLK_FREQ=4, BAUD_RATE=1 (CLKS_PER_BIT=4), DATA_WIDTH=16, MSG_QUEUE_SIZE=4. Check with the existing uart_rx receiver plus a cycle counter.

- Reset release, then 1 raw write of 0xA55A:
  - tx falls 2 edges after the write
  - receiver gets 0x5A then 0xA5
  - busy high for exactly 80 cycles
  - empty=1 one edge after the write edge + 1
- 1 hex write of 0x1F0C:
  - receiver gets 0x31, 0x46, 0x30, 0x43, 0x0D, 0x0A
  - busy high for 240 cycles
  - hex_mode toggled during transmission has no effect
- 6 raw writes on consecutive edges (0x0001..0x0006), starting idle:
  - full=1 after the 5th write edge
  - the 6th write is dropped; dropped=1
  - receiver gets the words 0x0001..0x0005 (10 bytes) in order
  - exactly 1 idle cycle between words
- wr held high for 300 cycles:
  - dropped saturates at 255 and stays there
  - the queue still drains in order
- Reset low during a DATA bit of the first character:
  - tx=1, busy=0, empty=1, dropped=0 immediately
  - after release, a raw write of 0x0041 yields 0x41, 0x00 with no residue from the aborted frame
- Alternating words, written back-to-back: raw 0x1234, hex 0x00FF, raw 0xBEEF:
  - receiver sequence 0x34, 0x12, '0','0','F','F', 0x0D, 0x0A, 0xEF, 0xBE
